// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by every pipeline register.
package cpu_pkg;

    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] PC_RESET  = 32'h0000_3000;
    localparam logic [DW-1:0] NOP_INSTR = 32'h0000_0000;

    typedef logic [DW-1:0] word_t;

endpackage : cpu_pkg

// File: rtl/pipe_field_reg.sv
// One pipeline-register field: async active-low reset to RESET_VAL, hold enable.
module pipe_field_reg #(
    parameter int unsigned  W         = 32,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next value: keep current contents while held, otherwise take the input.
    always_comb begin
        q_d = q_q;
        if (!hold_i) begin
            q_d = d_i;
        end
    end

    // Storage; reset clears immediately without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : pipe_field_reg

// File: rtl/mw_pipe_reg.sv
// MEM/WB pipeline register: five fields captured together, frozen by halt,
// cleared to a bubble by the asynchronous active-low reset.
module mw_pipe_reg
    import cpu_pkg::*;
#(
    parameter int unsigned   DW          = cpu_pkg::DW,
    parameter logic [DW-1:0] PC_RESET    = cpu_pkg::PC_RESET,
    parameter logic [DW-1:0] INSTR_RESET = cpu_pkg::NOP_INSTR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          halt,
    input  logic [DW-1:0] m_pc,
    input  logic [DW-1:0] m_instr,
    input  logic [DW-1:0] m_memRd,
    input  logic [DW-1:0] m_aluResult,
    input  logic [DW-1:0] m_extImm,
    output logic [DW-1:0] w_pc,
    output logic [DW-1:0] w_instr,
    output logic [DW-1:0] w_memRd,
    output logic [DW-1:0] w_aluResult,
    output logic [DW-1:0] w_extImm
);

    localparam logic [DW-1:0] ZERO = '0;

    // PC field resets to the boot vector.
    pipe_field_reg #(.W(DW), .RESET_VAL(PC_RESET)) u_pc (
        .clk    (clk),
        .rst_n  (reset),
        .hold_i (halt),
        .d_i    (m_pc),
        .q_o    (w_pc)
    );

    // Instruction field resets to a nop so write-back sees a bubble.
    pipe_field_reg #(.W(DW), .RESET_VAL(INSTR_RESET)) u_instr (
        .clk    (clk),
        .rst_n  (reset),
        .hold_i (halt),
        .d_i    (m_instr),
        .q_o    (w_instr)
    );

    // Data-memory read data.
    pipe_field_reg #(.W(DW), .RESET_VAL(ZERO)) u_mem_rd (
        .clk    (clk),
        .rst_n  (reset),
        .hold_i (halt),
        .d_i    (m_memRd),
        .q_o    (w_memRd)
    );

    // ALU result.
    pipe_field_reg #(.W(DW), .RESET_VAL(ZERO)) u_alu_result (
        .clk    (clk),
        .rst_n  (reset),
        .hold_i (halt),
        .d_i    (m_aluResult),
        .q_o    (w_aluResult)
    );

    // Extended immediate.
    pipe_field_reg #(.W(DW), .RESET_VAL(ZERO)) u_ext_imm (
        .clk    (clk),
        .rst_n  (reset),
        .hold_i (halt),
        .d_i    (m_extImm),
        .q_o    (w_extImm)
    );

endmodule : mw_pipe_reg

// File: tb/tb_mw_pipe_reg.sv
// Self-checking bench for mw_pipe_reg against a field-array reference model.
module tb_mw_pipe_reg;

    localparam int unsigned NF = 5;

    logic        clk;
    logic        reset;
    logic        halt;
    logic [31:0] in_v  [NF];
    logic [31:0] exp_v [NF];
    logic [31:0] out_v [NF];
    logic [31:0] rst_v [NF];

    logic [31:0] m_pc, m_instr, m_memRd, m_aluResult, m_extImm;
    logic [31:0] w_pc, w_instr, w_memRd, w_aluResult, w_extImm;

    int checks = 0;
    int errors = 0;

    assign m_pc        = in_v[0];
    assign m_instr     = in_v[1];
    assign m_memRd     = in_v[2];
    assign m_aluResult = in_v[3];
    assign m_extImm    = in_v[4];

    assign out_v[0] = w_pc;
    assign out_v[1] = w_instr;
    assign out_v[2] = w_memRd;
    assign out_v[3] = w_aluResult;
    assign out_v[4] = w_extImm;

    mw_pipe_reg dut (
        .clk         (clk),
        .reset       (reset),
        .halt        (halt),
        .m_pc        (m_pc),
        .m_instr     (m_instr),
        .m_memRd     (m_memRd),
        .m_aluResult (m_aluResult),
        .m_extImm    (m_extImm),
        .w_pc        (w_pc),
        .w_instr     (w_instr),
        .w_memRd     (w_memRd),
        .w_aluResult (w_aluResult),
        .w_extImm    (w_extImm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output field against the model.
    task automatic check_all(input string tag);
        for (int i = 0; i < NF; i++) begin
            chk($sformatf("%s_f%0d", tag, i), out_v[i], exp_v[i]);
        end
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < NF; i++) in_v[i] = v;
    endtask

    task automatic set_rand();
        for (int i = 0; i < NF; i++) in_v[i] = $urandom;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NF; i++) exp_v[i] = rst_v[i];
    endtask

    // One rising edge: model captures inputs only when out of reset and not halted.
    task automatic clock_and_check(input string tag);
        logic [31:0] nxt [NF];
        for (int i = 0; i < NF; i++) nxt[i] = (reset && !halt) ? in_v[i] : exp_v[i];
        @(posedge clk);
        #1;
        for (int i = 0; i < NF; i++) exp_v[i] = nxt[i];
        check_all(tag);
    endtask

    // Pull reset low partway through the cycle, check at once, release before next edge.
    task automatic mid_cycle_reset(input string tag);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        rst_v[0] = 32'h0000_3000;
        rst_v[1] = 32'h0;
        rst_v[2] = 32'h0;
        rst_v[3] = 32'h0;
        rst_v[4] = 32'h0;
        for (int i = 0; i < NF; i++) exp_v[i] = 32'h0;

        // Reset with no clock edge.
        halt  = 1'b0;
        reset = 1'b1;
        set_all(32'hDEAD_BEEF);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("rst_imm");

        // Clock edges during reset are ignored.
        for (int k = 0; k < 3; k++) clock_and_check("rst_hold");

        // Release and capture; outputs still at reset values just before the edge.
        @(negedge clk);
        reset    = 1'b1;
        in_v[0]  = 32'h0000_3004;
        in_v[1]  = 32'h8C01_0000;
        in_v[2]  = 32'h1234_5678;
        in_v[3]  = 32'h0000_0010;
        in_v[4]  = 32'hFFFF_FFF0;
        check_all("pre_edge");
        clock_and_check("capture");
        chk("capture_pc_abs", w_pc, 32'h0000_3004);

        // Halt for four edges with changed inputs.
        @(negedge clk);
        halt = 1'b1;
        set_all(32'hA5A5_A5A5);
        for (int k = 0; k < 4; k++) clock_and_check("halt");
        chk("halt_instr_abs", w_instr, 32'h8C01_0000);

        // Drop halt: next edge captures.
        @(negedge clk);
        halt = 1'b0;
        clock_and_check("unhalt");
        chk("unhalt_alu_abs", w_aluResult, 32'hA5A5_A5A5);

        // Async reset while halted.
        @(negedge clk);
        halt = 1'b1;
        set_rand();
        mid_cycle_reset("rst_in_halt");
        halt = 1'b0;
        set_rand();
        clock_and_check("post_rst_cap");

        // Back-to-back PC stream: one-cycle lag, no skips or duplicates.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_v[0] = 32'h0000_3000 + 32'(4 * k);
            clock_and_check("stream");
            chk("stream_pc_abs", w_pc, 32'h0000_3000 + 32'(4 * k));
        end

        // Randomised traffic with random halts and occasional mid-cycle resets.
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            halt = ($urandom_range(0, 3) == 0);
            set_rand();
            if ($urandom_range(0, 31) == 0) begin
                mid_cycle_reset("rnd_rst");
            end else begin
                clock_and_check("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mw_pipe_reg
